// File: rtl/multichannel_frequency_counter_pkg.sv
// Shared definitions for the multichannel frequency counter: stream FSM states,
// gate-length arithmetic and the counter saturation value.
package frequency_counter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

  // Gate length in clock cycles for a given minimum-gate exponent and selector.
  function automatic logic [31:0] gate_length(input int log2_min_gate, input logic [1:0] gate_sel);
    return 32'd1 << (log2_min_gate + int'(gate_sel));
  endfunction

  function automatic logic [63:0] saturation_max(input int counter_width);
    return (counter_width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << counter_width) - 64'd1);
  endfunction

endpackage

// File: rtl/multichannel_frequency_counter_if.sv
// Result stream of the frequency counter: one word per channel over valid/ready.
interface multichannel_frequency_counter_if #(
  parameter int COUNTER_WIDTH         = 24,
  parameter int LOG2_OF_CHANNEL_INDEX = 2
);

  logic [COUNTER_WIDTH-1:0]         result_value;
  logic                             result_overflow;
  logic [LOG2_OF_CHANNEL_INDEX-1:0] result_channel;
  logic                             result_valid;
  logic                             result_ready;

  modport master (
    output result_value,
    output result_overflow,
    output result_channel,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  result_value,
    input  result_overflow,
    input  result_channel,
    input  result_valid,
    output result_ready
  );

endinterface

// File: rtl/multichannel_frequency_counter_edge_counter_channel.sv
// One measured input: 2-flop synchroniser, rising-edge detect and a saturating
// edge counter with a sticky overflow bit, cleared at gate end unless totalizing.
module edge_counter_channel
  import frequency_counter_pkg::*;
#(
  parameter int COUNTER_WIDTH = 24
) (
  input  logic                     clock,
  input  logic                     resetb,
  input  logic                     i_signal,
  input  logic                     i_gate_clear,
  output logic [COUNTER_WIDTH-1:0] o_count,
  output logic                     o_overflow
);

  localparam logic [COUNTER_WIDTH-1:0] MAX_COUNT = COUNTER_WIDTH'(saturation_max(COUNTER_WIDTH));
  localparam logic [COUNTER_WIDTH-1:0] ONE       = COUNTER_WIDTH'(1);

  logic                     r_sync1;
  logic                     r_sync2;
  logic                     r_prev;
  logic [COUNTER_WIDTH-1:0] r_count;
  logic                     r_overflow;
  logic                     w_edge;

  assign w_edge = r_sync2 & ~r_prev;

  // An edge seen in the gate_end cycle is carried into the freshly cleared gate.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_prev     <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_sync1 <= i_signal;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (i_gate_clear) begin
        r_count    <= w_edge ? ONE : '0;
        r_overflow <= 1'b0;
      end else if (w_edge) begin
        if (r_count == MAX_COUNT) begin
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + ONE;
        end
      end
    end
  end

  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/multichannel_frequency_counter.sv
// Multichannel frequency counter: common gate timer, per-channel edge counters,
// gate-end snapshot and a valid/ready stream of one word per channel.
module multichannel_frequency_counter
  import frequency_counter_pkg::*;
#(
  parameter int NUMBER_OF_CHANNELS    = 4,
  parameter int COUNTER_WIDTH         = 24,
  parameter int LOG2_OF_MIN_GATE      = 20,
  parameter int LOG2_OF_CHANNEL_INDEX = 2
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic [NUMBER_OF_CHANNELS-1:0] signal_in,
  input  logic [1:0]                    gate_select,
  input  logic                          totalize,
  input  logic                          clear_overrun,
  multichannel_frequency_counter_if.master result_if,
  output logic                          gate_end,
  output logic                          overrun
);

  localparam int GATE_WIDTH = LOG2_OF_MIN_GATE + 3;
  localparam logic [LOG2_OF_CHANNEL_INDEX-1:0] LAST_INDEX = LOG2_OF_CHANNEL_INDEX'(NUMBER_OF_CHANNELS - 1);

  logic [GATE_WIDTH-1:0]            r_gate_count;
  logic [1:0]                       r_gate_select;
  logic [GATE_WIDTH-1:0]            w_gate_last;
  logic                             w_gate_end;

  logic [COUNTER_WIDTH-1:0]         w_count [NUMBER_OF_CHANNELS];
  logic [NUMBER_OF_CHANNELS-1:0]    w_overflow;
  logic [COUNTER_WIDTH-1:0]         r_snap_value [NUMBER_OF_CHANNELS];
  logic [NUMBER_OF_CHANNELS-1:0]    r_snap_overflow;

  stream_state_t                    r_state;
  logic [LOG2_OF_CHANNEL_INDEX-1:0] r_index;
  logic [LOG2_OF_CHANNEL_INDEX-1:0] w_next_index;
  logic                             r_valid;
  logic [COUNTER_WIDTH-1:0]         r_result_value;
  logic                             r_result_overflow;
  logic                             r_overrun;
  logic                             w_accept;
  logic                             w_last_word;
  logic                             w_take_snapshot;

  assign w_gate_last = GATE_WIDTH'(gate_length(LOG2_OF_MIN_GATE, r_gate_select) - 32'd1);
  assign w_gate_end  = (r_gate_count == w_gate_last);

  // The selector is latched only at gate end so a running gate is never cut short.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_gate_count  <= '0;
      r_gate_select <= 2'd0;
    end else if (w_gate_end) begin
      r_gate_count  <= '0;
      r_gate_select <= gate_select;
    end else begin
      r_gate_count <= r_gate_count + GATE_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < NUMBER_OF_CHANNELS; g++) begin : g_channel
    edge_counter_channel #(
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_channel (
      .clock       (clock),
      .resetb      (resetb),
      .i_signal    (signal_in[g]),
      .i_gate_clear(w_gate_end & ~totalize),
      .o_count     (w_count[g]),
      .o_overflow  (w_overflow[g])
    );
  end

  assign w_accept        = r_valid & result_if.result_ready;
  assign w_last_word     = (r_index == LAST_INDEX);
  assign w_next_index    = r_index + LOG2_OF_CHANNEL_INDEX'(1);
  assign w_take_snapshot = w_gate_end & ((r_state == IDLE) | (w_accept & w_last_word));

  // A gate end that lands on the final accepted word restarts the stream instead of overrunning.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state           <= IDLE;
      r_index           <= '0;
      r_valid           <= 1'b0;
      r_result_value    <= '0;
      r_result_overflow <= 1'b0;
      r_overrun         <= 1'b0;
      r_snap_overflow   <= '0;
      for (int i = 0; i < NUMBER_OF_CHANNELS; i++) begin
        r_snap_value[i] <= '0;
      end
    end else begin
      if (w_gate_end & ~w_take_snapshot) begin
        r_overrun <= 1'b1;
      end else if (clear_overrun) begin
        r_overrun <= 1'b0;
      end

      if (w_take_snapshot) begin
        for (int i = 0; i < NUMBER_OF_CHANNELS; i++) begin
          r_snap_value[i] <= w_count[i];
        end
        r_snap_overflow   <= w_overflow;
        r_state           <= STREAM;
        r_index           <= '0;
        r_valid           <= 1'b1;
        r_result_value    <= w_count[0];
        r_result_overflow <= w_overflow[0];
      end else if (w_accept) begin
        if (w_last_word) begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end else begin
          r_index           <= w_next_index;
          r_result_value    <= r_snap_value[w_next_index];
          r_result_overflow <= r_snap_overflow[w_next_index];
        end
      end
    end
  end

  assign result_if.result_value    = r_result_value;
  assign result_if.result_overflow = r_result_overflow;
  assign result_if.result_channel  = r_index;
  assign result_if.result_valid    = r_valid;
  assign gate_end                  = w_gate_end;
  assign overrun                   = r_overrun;

endmodule

// File: tb/tb_multichannel_frequency_counter.sv
// Directed bench for multichannel_frequency_counter: 8-bit main instance plus a
// 4-bit instance for saturation, driven by a table of gates and corner-case sequences.
module tb_multichannel_frequency_counter;

  typedef struct {
    logic [1:0] gateSel;
    logic       tot;
    int         expGateLen;
    logic [7:0] expCh0;
  } vector_t;

  logic       clock = 1'b0;
  logic       resetb;
  logic [3:0] signalMain = 4'd0;
  logic [3:0] signalSmall = 4'd0;
  logic [1:0] gateSelect;
  logic       totalize;
  logic       clearOverrun;
  logic       gateEnd;
  logic       overrun;
  logic       gateEndSmall;
  logic       overrunSmall;
  int         checks = 0;
  int         failures = 0;
  int         cycle = 0;
  int         tick = 0;
  vector_t    vectors [7];

  multichannel_frequency_counter_if #(.COUNTER_WIDTH(8), .LOG2_OF_CHANNEL_INDEX(2)) ifMain ();
  multichannel_frequency_counter_if #(.COUNTER_WIDTH(4), .LOG2_OF_CHANNEL_INDEX(2)) ifSmall ();

  multichannel_frequency_counter #(
    .NUMBER_OF_CHANNELS(4), .COUNTER_WIDTH(8), .LOG2_OF_MIN_GATE(6), .LOG2_OF_CHANNEL_INDEX(2)
  ) dutMain (
    .clock(clock), .resetb(resetb), .signal_in(signalMain), .gate_select(gateSelect),
    .totalize(totalize), .clear_overrun(clearOverrun), .result_if(ifMain),
    .gate_end(gateEnd), .overrun(overrun)
  );

  multichannel_frequency_counter #(
    .NUMBER_OF_CHANNELS(4), .COUNTER_WIDTH(4), .LOG2_OF_MIN_GATE(6), .LOG2_OF_CHANNEL_INDEX(2)
  ) dutSmall (
    .clock(clock), .resetb(resetb), .signal_in(signalSmall), .gate_select(2'd0),
    .totalize(1'b0), .clear_overrun(1'b0), .result_if(ifSmall),
    .gate_end(gateEndSmall), .overrun(overrunSmall)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  // Stimulus phase restarts while reset is held so every first gate sees the same edge positions.
  always @(negedge clock) begin
    if (!resetb) tick = 0;
    else tick = tick + 1;
    signalMain  = {3'b000, tick[2]};
    signalSmall = {1'b0, tick[0], 2'b00};
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic tot);
    gateSelect = sel;
    totalize   = tot;
  endtask

  function automatic logic [31:0] wordMain();
    return {20'd0, ifMain.result_valid, ifMain.result_channel, ifMain.result_overflow, ifMain.result_value};
  endfunction

  function automatic logic [31:0] expectedWord(input int ch, input logic [7:0] val);
    return {20'd0, 1'b1, 2'(ch), 1'b0, val};
  endfunction

  function automatic logic [31:0] wordSmall();
    return {24'd0, ifSmall.result_valid, ifSmall.result_channel, ifSmall.result_overflow, ifSmall.result_value};
  endfunction

  function automatic logic [31:0] expectedSmall(input int ch);
    if (ch == 2) return {24'd0, 1'b1, 2'd2, 1'b1, 4'hF};
    return {24'd0, 1'b1, 2'(ch), 1'b0, 4'h0};
  endfunction

  task automatic waitGateEnd(input int budget, output int when);
    when = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (gateEnd === 1'b1) begin
        when = cycle;
        break;
      end
    end
    if (when < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL gate_end_timeout: got no pulse, expected one within %0d cycles", budget);
    end
  endtask

  task automatic collectStream(input string tag, input int firstCh, input logic [7:0] expCh0);
    for (int ch = firstCh; ch < 4; ch++) begin
      @(negedge clock);
      checkOutput($sformatf("%s_word%0d", tag, ch), wordMain(), expectedWord(ch, (ch == 0) ? expCh0 : 8'd0));
    end
  endtask

  initial begin
    int when;
    int lastGate;
    int gate9;
    int releaseCycle;
    int stallBad;
    int stallGateEnds;
    logic overrunEarly;

    // ch0 rises every 8 clocks: 8 edges per 64-cycle gate, 16 per 128-cycle gate.
    vectors[0] = '{2'd0, 1'b0, 64,  8'd8};
    vectors[1] = '{2'd1, 1'b0, 64,  8'd8};
    vectors[2] = '{2'd0, 1'b0, 128, 8'd16};
    vectors[3] = '{2'd0, 1'b1, 64,  8'd8};
    vectors[4] = '{2'd0, 1'b1, 64,  8'd16};
    vectors[5] = '{2'd0, 1'b0, 64,  8'd24};
    vectors[6] = '{2'd0, 1'b0, 64,  8'd8};

    resetb       = 1'b0;
    clearOverrun = 1'b0;
    applyStimulus(2'd0, 1'b0);
    ifMain.result_ready  = 1'b1;
    ifSmall.result_ready = 1'b1;

    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset_valid",    32'(ifMain.result_valid),    32'd0);
    checkOutput("reset_value",    32'(ifMain.result_value),    32'd0);
    checkOutput("reset_overflow", 32'(ifMain.result_overflow), 32'd0);
    checkOutput("reset_channel",  32'(ifMain.result_channel),  32'd0);
    checkOutput("reset_gate_end", 32'(gateEnd),                32'd0);
    checkOutput("reset_overrun",  32'(overrun),                32'd0);

    @(negedge clock);
    #2 resetb = 1'b1;
    releaseCycle = cycle;

    // The release cycle holds gate count 0, so gate_end shows 63 posedges later.
    waitGateEnd(200, when);
    checkOutput("gate1_len", 32'(when - releaseCycle), 32'd63);
    checkOutput("gate1_small_gate_end", 32'(gateEndSmall), 32'd1);
    for (int ch = 0; ch < 4; ch++) begin
      @(negedge clock);
      checkOutput($sformatf("gate1_word%0d", ch), wordMain(), expectedWord(ch, (ch == 0) ? 8'd8 : 8'd0));
      checkOutput($sformatf("small_sat_word%0d", ch), wordSmall(), expectedSmall(ch));
    end
    checkOutput("small_overrun", 32'(overrunSmall), 32'd0);
    lastGate = when;

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vectors[v].gateSel, vectors[v].tot);
      waitGateEnd(300, when);
      checkOutput($sformatf("vec%0d_gate_len", v), 32'(when - lastGate), 32'(vectors[v].expGateLen));
      lastGate = when;
      collectStream($sformatf("vec%0d", v), 0, vectors[v].expCh0);
    end

    // Backpressure across a gate end: totalize makes the dropped snapshot (16) differ from the held one (8).
    applyStimulus(2'd0, 1'b1);
    waitGateEnd(300, when);
    checkOutput("gate9_len", 32'(when - lastGate), 32'd64);
    gate9 = when;
    ifMain.result_ready = 1'b0;
    stallBad = 0;
    stallGateEnds = 0;
    overrunEarly = 1'bx;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (wordMain() !== expectedWord(0, 8'd8)) stallBad++;
      if (gateEnd === 1'b1) stallGateEnds++;
      if (i == 10) overrunEarly = overrun;
    end
    checkOutput("stall_unstable_cycles", 32'(stallBad), 32'd0);
    checkOutput("stall_gate_end_count", 32'(stallGateEnds), 32'd1);
    checkOutput("overrun_before_drop", 32'(overrunEarly), 32'd0);
    checkOutput("overrun_after_drop", 32'(overrun), 32'd1);
    ifMain.result_ready = 1'b1;
    collectStream("released", 1, 8'd0);

    clearOverrun = 1'b1;
    @(negedge clock);
    clearOverrun = 1'b0;
    checkOutput("overrun_cleared", 32'(overrun), 32'd0);
    applyStimulus(2'd0, 1'b0);

    // Totalized from gate 8 end through gate 11: 192 cycles of ch0 edges.
    waitGateEnd(300, when);
    checkOutput("gate11_len", 32'(when - gate9), 32'd128);
    @(negedge clock);
    checkOutput("gate11_word0", wordMain(), expectedWord(0, 8'd24));
    @(negedge clock);
    checkOutput("gate11_word1", wordMain(), expectedWord(1, 8'd0));
    @(negedge clock);
    checkOutput("gate11_word2_before_reset", wordMain(), expectedWord(2, 8'd0));
    #2 resetb = 1'b0;
    #1;
    checkOutput("async_reset_word", wordMain(), 32'd0);
    checkOutput("async_reset_overrun", 32'(overrun), 32'd0);
    @(negedge clock);
    #2 resetb = 1'b1;
    releaseCycle = cycle;
    waitGateEnd(200, when);
    checkOutput("post_reset_len", 32'(when - releaseCycle), 32'd63);
    collectStream("post_reset", 0, 8'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
